// File: rtl/reg_write_merge_if.sv
// Write-merge bus: channels A and B (valid/ready + data), the merged write port
// driving the downstream register, and the statistics counters.
// The slave modport is the merge stage; the master modport is its environment.
interface reg_write_merge_if #(
   parameter int unsigned width = 1
);
   logic             VALID_A;
   logic [width-1:0] DATA_A;
   logic             READY_A;
   logic             VALID_B;
   logic [width-1:0] DATA_B;
   logic             READY_B;
   logic             WR_EN;
   logic [width-1:0] WR_DATA;
   logic             WR_SRC;
   logic [15:0]      STAT_A;
   logic [15:0]      STAT_B;
   logic [15:0]      STAT_FORCED;

   modport master (
      output VALID_A, DATA_A, VALID_B, DATA_B,
      input  READY_A, READY_B, WR_EN, WR_DATA, WR_SRC, STAT_A, STAT_B, STAT_FORCED
   );

   modport slave (
      input  VALID_A, DATA_A, VALID_B, DATA_B,
      output READY_A, READY_B, WR_EN, WR_DATA, WR_SRC, STAT_A, STAT_B, STAT_FORCED
   );
endinterface

// File: rtl/reg_write_merge.sv
// reg_write_merge: merges two valid/ready write channels into one registered
// write strobe. Each channel has a one-entry buffer; A has fixed priority and
// B is forced through after STARVE_LIMIT blocked cycles.
// Optional statistics counters: define REG_WRITE_MERGE_STATS_EN to build them,
// otherwise the STAT ports read zero.
module reg_write_merge #(
   parameter int unsigned      width        = 1,
   parameter logic [width-1:0] init         = '0,
   parameter int unsigned      STARVE_LIMIT = 4
) (
   input logic              CLK,
   input logic              RST_N,
   reg_write_merge_if.slave bus
);
   localparam logic [7:0] starve_limit = 8'(STARVE_LIMIT);

   logic             full_a_q, full_a_d;
   logic             full_b_q, full_b_d;
   logic [width-1:0] buf_a_q, buf_a_d;
   logic [width-1:0] buf_b_q, buf_b_d;
   logic [7:0]       wait_b_q, wait_b_d;
   logic             wr_en_q, wr_en_d;
   logic [width-1:0] wr_data_q, wr_data_d;
   logic             wr_src_q, wr_src_d;

   logic force_b, grant_a, grant_b;
   logic ready_a, ready_b, xfer_a, xfer_b;

   // Arbitration from buffer state only; B wins when A is empty or B has starved.
   always_comb begin
      force_b = full_b_q && (wait_b_q >= starve_limit);
      grant_b = full_b_q && (!full_a_q || force_b);
      grant_a = full_a_q && !grant_b;
   end

   // A granted buffer frees up this cycle, so it can refill on the same edge.
   assign ready_a = RST_N && (!full_a_q || grant_a);
   assign ready_b = RST_N && (!full_b_q || grant_b);
   assign xfer_a  = bus.VALID_A && ready_a;
   assign xfer_b  = bus.VALID_B && ready_b;

   // Next-state for buffers, starvation counter and write port.
   always_comb begin
      full_a_d  = full_a_q;
      buf_a_d   = buf_a_q;
      full_b_d  = full_b_q;
      buf_b_d   = buf_b_q;
      wait_b_d  = wait_b_q;
      if (xfer_a) begin
         full_a_d = 1'b1;
         buf_a_d  = bus.DATA_A;
      end else if (grant_a) begin
         full_a_d = 1'b0;
      end
      if (xfer_b) begin
         full_b_d = 1'b1;
         buf_b_d  = bus.DATA_B;
      end else if (grant_b) begin
         full_b_d = 1'b0;
      end
      // Counts cycles the current B entry has been blocked; saturates.
      if (!full_b_q || grant_b) begin
         wait_b_d = 8'd0;
      end else if (wait_b_q != 8'hFF) begin
         wait_b_d = wait_b_q + 8'd1;
      end
      wr_en_d   = grant_a || grant_b;
      wr_src_d  = grant_b;
      wr_data_d = wr_data_q;
      if (grant_b) begin
         wr_data_d = buf_b_q;
      end else if (grant_a) begin
         wr_data_d = buf_a_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         full_a_q  <= 1'b0;
         full_b_q  <= 1'b0;
         buf_a_q   <= '0;
         buf_b_q   <= '0;
         wait_b_q  <= 8'd0;
         wr_en_q   <= 1'b0;
         wr_data_q <= init;
         wr_src_q  <= 1'b0;
      end else begin
         full_a_q  <= full_a_d;
         full_b_q  <= full_b_d;
         buf_a_q   <= buf_a_d;
         buf_b_q   <= buf_b_d;
         wait_b_q  <= wait_b_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         wr_src_q  <= wr_src_d;
      end
   end

   assign bus.READY_A = ready_a;
   assign bus.READY_B = ready_b;
   assign bus.WR_EN   = wr_en_q;
   assign bus.WR_DATA = wr_data_q;
   assign bus.WR_SRC  = wr_src_q;

`ifdef REG_WRITE_MERGE_STATS_EN
   logic [15:0] stat_a_q, stat_b_q, stat_forced_q;

   // Saturating per-source write counts and count of forced B grants over a full A.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         stat_a_q      <= 16'h0000;
         stat_b_q      <= 16'h0000;
         stat_forced_q <= 16'h0000;
      end else begin
         if (grant_a && (stat_a_q != 16'hFFFF)) begin
            stat_a_q <= stat_a_q + 16'd1;
         end
         if (grant_b && (stat_b_q != 16'hFFFF)) begin
            stat_b_q <= stat_b_q + 16'd1;
         end
         if (force_b && full_a_q && (stat_forced_q != 16'hFFFF)) begin
            stat_forced_q <= stat_forced_q + 16'd1;
         end
      end
   end

   assign bus.STAT_A      = stat_a_q;
   assign bus.STAT_B      = stat_b_q;
   assign bus.STAT_FORCED = stat_forced_q;
`else
   assign bus.STAT_A      = 16'h0000;
   assign bus.STAT_B      = 16'h0000;
   assign bus.STAT_FORCED = 16'h0000;
`endif
endmodule

// File: doc/reg_write_merge.md
# reg_write_merge

Upstream write-merge stage for a two-input priority register. It accepts write requests from two independent valid/ready channels (A and B) and holds each in a one-entry buffer. Each cycle it picks at most one buffered request and presents it as a registered single-cycle write strobe with data. Channel A has fixed priority; an anti-starvation counter forces a B grant after a bounded wait. Its outputs drive the register's enable/data inputs directly, so no write is ever silently lost to the lower-priority port.

## Interface

Parameters:
- `width`, 1, data width of both channels and the write output
- `init`, `{width{1'b0}}`, reset value of `WR_DATA`
- `STARVE_LIMIT`, 4, consecutive blocked cycles after which B is granted over A; legal range 1..255

Ports:
- `CLK`  in  1  clock, all state updates on posedge
- `RST_N`  in  1  reset, synchronous, active-low
- `VALID_A`  in  1  channel A request valid
- `DATA_A`  in  width  channel A write data
- `READY_A`  out  1  channel A may transfer this cycle
- `VALID_B`  in  1  channel B request valid
- `DATA_B`  in  width  channel B write data
- `READY_B`  out  1  channel B may transfer this cycle
- `WR_EN`  out  1  registered write strobe to the downstream register
- `WR_DATA`  out  width  registered write data, valid when `WR_EN`=1
- `WR_SRC`  out  1  source of the current write: 0 = A, 1 = B; meaningful only when `WR_EN`=1
- `STAT_A`, `STAT_B`, `STAT_FORCED`  out  16 each  statistics counters (see Configuration)

## Operation

- Per channel x, a one-entry holding buffer `full_x`/`buf_x`.
- Transfer on channel x occurs at a posedge where `VALID_x && READY_x`.
- `READY_x = RST_N && (!full_x || grant_x)`. A granted buffer may refill in the same cycle (full throughput: one write per cycle per channel when uncontested).
- Grant logic is combinational from buffer state and drives the registered output.
  - `force_b = full_b && (wait_b >= STARVE_LIMIT)`
  - `grant_b = full_b && (!full_a || force_b)`
  - `grant_a = full_a && !grant_b`
  - At most one grant per cycle.
- Output register, updated at each posedge:
  - `WR_EN <= grant_a || grant_b`
  - `WR_DATA` is loaded with the granted buffer's data; it holds its value when there is no grant.
  - `WR_SRC <= grant_b`
- Buffer update: `full_x` is set on transfer and cleared on grant without transfer. The buffer data is loaded on transfer.
- Starvation counter `wait_b` (8-bit, saturating at 255):
  - cleared when `!full_b` or on `grant_b`
  - incremented when `full_b && !grant_b`
- The two channels are independent. Simultaneous A and B transfers are both accepted, and each goes into its own buffer.

## Timing

- Reset values while `RST_N`=0 at a posedge:
  - `WR_EN`=0, `WR_DATA`=`init`, `WR_SRC`=0
  - `full_a`=`full_b`=0, `wait_b`=0, all STAT counters 0
  - `READY_A`=`READY_B`=0 combinationally during reset
- Latency: a transfer at edge t fills the buffer. If granted in cycle t..t+1, `WR_EN`=1 is visible after edge t+1, giving 2-edge latency uncontested.
- Contention with both buffers full: A wins. B is granted on the first cycle in which `wait_b` has reached `STARVE_LIMIT`.
  - With A saturated, B writes once every `STARVE_LIMIT`+1 cycles.
- A is backpressured (`READY_A`=0) only while A is full and not granted, i.e. during a forced B grant.
- Reset mid-operation: buffered requests are discarded and no write strobe is issued after reset. The upstream must re-present the requests.
- `WR_EN` is never high on two consecutive cycles carrying the same buffered request. Each accepted request produces exactly one write.

## Configuration

- Macro: `REG_WRITE_MERGE_STATS_EN`.
- Defined:
  - `STAT_A` and `STAT_B` count writes issued per source.
  - `STAT_FORCED` counts grants where `force_b`=1 while `full_a`=1.
  - All counters are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: the counter logic is absent and all three STAT ports are tied to 16'h0000. The ports remain present so the interface is identical in both builds.

## Test plan

- Reset: hold `RST_N`=0 for 3 cycles with `VALID_A`=`VALID_B`=1 -> `READY_A`=`READY_B`=0, `WR_EN`=0, `WR_DATA`=`init`. After release, no spurious write occurs.
- Single A request: one-cycle `VALID_A` with `DATA_A`=8'h5A -> `WR_EN`=1 for exactly one cycle, 2 edges later, with `WR_DATA`=8'h5A and `WR_SRC`=0.
- Simultaneous A and B: A=8'h11 and B=8'h22 transferred on the same edge -> writes 8'h11 (`WR_SRC`=0), then 8'h22 (`WR_SRC`=1) on consecutive cycles.
- Starvation: `STARVE_LIMIT`=4, `VALID_A` held 1 with incrementing data, one B request 8'hBB -> 8'hBB is written as the 5th write after B is buffered. `READY_A`=0 for exactly that grant cycle. With STATS on, `STAT_FORCED` increments by 1.
- Back-to-back B only: B streams 8 values with `VALID_B` held -> `READY_B` stays 1 and 8 consecutive `WR_EN` pulses carry the values in order.
- Reset mid-stream: assert `RST_N`=0 with both buffers full -> no writes follow reset, and with STATS on all counters read 0.
